// File: rtl/alu_regfile_pkg.sv
// Shared widths, PSR flag bit positions and ALU opcode encodings for the datapath.
// Latency: n/a (constants only). Backpressure: n/a.
package alu_regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;
    localparam int FLAG_W   = 5;

    // PSR bit positions, shared with the ALU's Flags output
    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        CMP  = 4'd2,
        AND  = 4'd3,
        OR   = 4'd4,
        XOR  = 4'd5,
        NOT  = 4'd6,
        LSH  = 4'd7,
        RSH  = 4'd8,
        ARSH = 4'd9
    } alu_op_e;

endpackage

// File: rtl/psr_reg.sv
// Status register: loads the ALU flags when enabled, otherwise holds; sync active-high clear.
// Latency: 1 cycle from en to q. Backpressure: none, loads unconditionally when enabled.
module psr_reg
    import alu_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [FLAG_W-1:0] d,
    output logic [FLAG_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/alu_regfile.sv
// 16x16 register file feeding the ALU operands, with write-back bypass and the PSR.
// Latency: reads 0 cycles (write-through), write-back and PSR load 1 cycle. Backpressure: none.
module alu_regfile
    import alu_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RsrcAddr,
    input  logic [ADDR_W-1:0] RdestAddr,
    output logic [DATA_W-1:0] RsrcData,
    output logic [DATA_W-1:0] RdestData,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              FlagsEn,
    input  logic [FLAG_W-1:0] FlagsIn,
    output logic [FLAG_W-1:0] PSR
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (WrEn) begin
            regs[WrAddr] <= WrData;
        end
    end

    // Forward the in-flight write-back so the ALU never sees a stale operand;
    // reset forces zeros because the write it would forward is being discarded.
    always_comb begin
        RsrcData  = regs[RsrcAddr];
        RdestData = regs[RdestAddr];
        if (reset) begin
            RsrcData  = '0;
            RdestData = '0;
        end else begin
            if (WrEn && (WrAddr == RsrcAddr)) begin
                RsrcData = WrData;
            end
            if (WrEn && (WrAddr == RdestAddr)) begin
                RdestData = WrData;
            end
        end
    end

    psr_reg u_psr_reg (
        .clk   (clk),
        .reset (reset),
        .en    (FlagsEn),
        .d     (FlagsIn),
        .q     (PSR)
    );

endmodule

// File: tb/tb_alu_regfile.sv
// Directed self-checking bench for alu_regfile: reset, write-back, bypass, PSR load/hold, reset priority.
module tb_alu_regfile;
    import alu_regfile_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] RsrcAddr;
    logic [ADDR_W-1:0] RdestAddr;
    logic [DATA_W-1:0] RsrcData;
    logic [DATA_W-1:0] RdestData;
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [DATA_W-1:0] WrData;
    logic              FlagsEn;
    logic [FLAG_W-1:0] FlagsIn;
    logic [FLAG_W-1:0] PSR;

    int errors = 0;
    int checks = 0;

    alu_regfile dut (
        .clk       (clk),
        .reset     (reset),
        .RsrcAddr  (RsrcAddr),
        .RdestAddr (RdestAddr),
        .RsrcData  (RsrcData),
        .RdestData (RdestData),
        .WrEn      (WrEn),
        .WrAddr    (WrAddr),
        .WrData    (WrData),
        .FlagsEn   (FlagsEn),
        .FlagsIn   (FlagsIn),
        .PSR       (PSR)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge; inputs are then changed and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        WrEn = 1'b1; WrAddr = a; WrData = d;
        tick();
        WrEn = 1'b0;
    endtask

    initial begin
        reset = 1'b1; WrEn = 1'b1; WrAddr = 4'd3; WrData = 16'hFFFF;
        RsrcAddr = 4'd3; RdestAddr = 4'd3; FlagsEn = 1'b1; FlagsIn = 5'b11111;
        settle();
        chk("rst_bypass_off_a", RsrcData, 16'h0000);
        chk("rst_bypass_off_b", RdestData, 16'h0000);
        tick();
        tick();
        reset = 1'b0; WrEn = 1'b0; FlagsEn = 1'b0;
        settle();
        for (int i = 0; i < NUM_REGS; i++) begin
            RsrcAddr = ADDR_W'(i); RdestAddr = ADDR_W'(NUM_REGS - 1 - i);
            settle();
            chk($sformatf("rst_reg_a%0d", i), RsrcData, 16'h0000);
            chk($sformatf("rst_reg_b%0d", NUM_REGS - 1 - i), RdestData, 16'h0000);
        end
        chk("rst_psr", {11'd0, PSR}, 16'h0000);

        // R1 = R2 = 1, then ADD write-back of 2 into R2
        wr(4'd1, 16'h0001);
        wr(4'd2, 16'h0001);
        RsrcAddr = 4'd1; RdestAddr = 4'd2;
        settle();
        chk("add_src", RsrcData, 16'h0001);
        chk("add_dst", RdestData, 16'h0001);
        WrEn = 1'b1; WrAddr = 4'd2; WrData = 16'h0002;
        settle();
        chk("add_wb_bypass_b", RdestData, 16'h0002);
        chk("add_wb_no_bypass_a", RsrcData, 16'h0001);
        tick();
        WrEn = 1'b0;
        settle();
        chk("add_r2_after", RdestData, 16'h0002);
        chk("add_r1_kept", RsrcData, 16'h0001);

        // Bypass on both ports over a stale R5
        wr(4'd5, 16'h1111);
        RsrcAddr = 4'd5; RdestAddr = 4'd5;
        settle();
        chk("r5_old", RsrcData, 16'h1111);
        WrEn = 1'b1; WrAddr = 4'd5; WrData = 16'hBEEF;
        settle();
        chk("bypass_a", RsrcData, 16'hBEEF);
        chk("bypass_b", RdestData, 16'hBEEF);
        tick();
        WrEn = 1'b0;
        settle();
        chk("r5_stored", RdestData, 16'hBEEF);

        // PSR load, no bypass, then hold
        FlagsEn = 1'b1; FlagsIn = 5'b01000;
        settle();
        chk("psr_no_bypass", {11'd0, PSR}, 16'h0000);
        tick();
        FlagsEn = 1'b0; FlagsIn = 5'b10001;
        settle();
        chk("psr_loaded", {11'd0, PSR}, 16'h0008);
        tick();
        tick();
        chk("psr_hold", {11'd0, PSR}, 16'h0008);

        // Simultaneous write-back and flag load
        WrEn = 1'b1; WrAddr = 4'd3; WrData = 16'h8000;
        FlagsEn = 1'b1; FlagsIn = 5'b10000;
        tick();
        WrEn = 1'b0; FlagsEn = 1'b0;
        RsrcAddr = 4'd3;
        settle();
        chk("same_edge_r3", RsrcData, 16'h8000);
        chk("same_edge_psr", {11'd0, PSR}, 16'h0010);

        // R0 is writable storage
        wr(4'd0, 16'hA5A5);
        RsrcAddr = 4'd0;
        settle();
        chk("r0_writable", RsrcData, 16'hA5A5);

        // Reset beats a same-cycle write and flag load
        reset = 1'b1;
        WrEn = 1'b1; WrAddr = 4'd7; WrData = 16'h1234;
        FlagsEn = 1'b1; FlagsIn = 5'b11111;
        tick();
        reset = 1'b0; WrEn = 1'b0; FlagsEn = 1'b0;
        RsrcAddr = 4'd7; RdestAddr = 4'd3;
        settle();
        chk("rst_win_r7", RsrcData, 16'h0000);
        chk("rst_win_r3", RdestData, 16'h0000);
        chk("rst_win_psr", {11'd0, PSR}, 16'h0000);
        wr(4'd7, 16'h1234);
        settle();
        chk("post_rst_write", RsrcData, 16'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
